multiword_adder_seq: RTL and testbench
======================================

// Module: multiword_adder_seq
// PURPOSE
//  Sequential multi-precision adder. Adds WIDTH-bit operands over NSLICE = WIDTH/SLICE cycles.
//  Each cycle, one SLICE-bit carry-lookahead adder processes one slice, LSB slice first.
//  A registered carry feeds each slice's cout into the next slice's cin.
//  Sits between a valid/ready operand source and a valid/ready result sink.
//  Used where a full-width single-cycle adder would miss timing.
// PARAMETERS
//  WIDTH  128  operand/result width in bits; must be a multiple of SLICE (elaboration $error otherwise)
//  SLICE  32   bits added per cycle; NSLICE = WIDTH/SLICE; NSLICE = 1 is legal
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to slice 0
//  sub        in   1      1 = a - b (present only with SUBTRACT_EN)
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      sink accepts result
//  sum        out  WIDTH  registered result
//  cout       out  1      carry out of MSB slice
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0; carry_q=0; idx=0.
//   - Reset mid-RUN or in DONE aborts the op and discards the result; no partial result is ever flagged valid.
//  FSM:
//   - IDLE: on in_valid&&in_ready, register a and b, carry_q<=cin, idx<=0, go to RUN.
//   - RUN: each cycle, sum[idx*SLICE +: SLICE] <= slice sum and carry_q <= slice cout.
//     If idx==NSLICE-1: cout <= slice cout, go to DONE. Otherwise idx++.
//   - DONE: out_valid=1. sum and cout hold stable until out_valid&&out_ready; then go to IDLE.
//  Timing:
//   - Latency: out_valid rises NSLICE clock edges after the accepting edge.
//   - Minimum issue interval: NSLICE+2 cycles.
//   - in_ready is never high in DONE, so no accept overlaps a pending result.
//  Data rules:
//   - Inputs are sampled only at acceptance; changes to a, b, cin, sub while busy have no effect.
//   - Arithmetic is modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
//   - sum holds its last value in IDLE (not cleared).
// CONFIGURATION
//  SUBTRACT_EN defined:
//   - sub port exists. When sub=1 at acceptance: b is stored inverted and carry_q<=1 (cin ignored).
//   - Result is a-b mod 2^WIDTH; cout=1 means no borrow (a>=b unsigned).
//  SUBTRACT_EN undefined: no sub port; the block adds only.
// STRUCTURE
//  Package adder_pkg:
//   - state enum {IDLE, RUN, DONE}
//   - default SLICE localparam
//   - clog2-based idx width helper
//  One sub-module: carry_lookahead_adder #(.N(SLICE)), instantiated once.
//   - Driven by the idx-selected operand slices and carry_q.
//  Operand registers, slice mux, carry register and FSM live in this module.
// TESTING  (WIDTH=128, SLICE=32 unless noted)
//  1. a=2^128-1, b=1, cin=0
//     -> sum=0, cout=1; out_valid exactly 4 edges after accept.
//  2. a=0x0000_0000_FFFF_FFFF, b=1
//     -> sum=0x1_0000_0000, cout=0 (carry crosses the slice boundary).
//  3. out_ready=0 for 10 cycles in DONE
//     -> out_valid, sum, cout stable; in_ready=0; busy=1 throughout.
//  4. rst_n pulsed low after 2 RUN cycles
//     -> out_valid=0, sum=0, in_ready=1 after release; the next op a=3, b=4 gives sum=7.
//  5. SUBTRACT_EN: a=5, b=7, sub=1 -> sum=2^128-2, cout=0.
//     a=7, b=5, sub=1 -> sum=2, cout=1.
//  6. in_valid held with two ops, out_ready=1
//     -> both results in order; second accepted the cycle after the first DONE handshake.
//     Repeat with SLICE=128 (NSLICE=1).

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the sequential multi-word adder.
// Holds the FSM state encoding, default slice width and the index-width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_SLICE = 32;

    // Width of the slice index; a single-slice build still needs a 1-bit register.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit generate/propagate adder used once per cycle on one operand slice.
// Carries are formed from per-bit generate/propagate terms so synthesis can map them onto fast carry logic.
module carry_lookahead_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N-1:0] carry_in_bit;
    logic         carry_out_msb;

    for (genvar gi = 0; gi < N; gi++) begin : g_gp
        assign gen[gi]  = a[gi] & b[gi];
        assign prop[gi] = a[gi] ^ b[gi];
    end

    // A local running carry avoids a signal that depends on its own bits.
    always_comb begin
        logic c;
        c            = cin;
        carry_in_bit = '0;
        for (int i = 0; i < N; i++) begin
            carry_in_bit[i] = c;
            c = gen[i] | (prop[i] & c);
        end
        carry_out_msb = c;
    end

    assign sum  = prop ^ carry_in_bit;
    assign cout = carry_out_msb;

endmodule

// File: rtl/multiword_adder_seq.sv
// Sequential multi-precision adder: one SLICE-bit slice per cycle, LSB slice first, with a registered carry.
// Optional feature macro: SUBTRACT_EN adds the sub port and a - b support.
module multiword_adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = idx_width(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("multiword_adder_seq: WIDTH must be a multiple of SLICE");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic [SLICE-1:0]  a_slice;
    logic [SLICE-1:0]  b_slice;
    logic [SLICE-1:0]  slice_sum;
    logic              slice_cout;

    assign a_slice = a_q[int'(idx_q) * SLICE +: SLICE];
    assign b_slice = b_q[int'(idx_q) * SLICE +: SLICE];

    carry_lookahead_adder #(.N(SLICE)) u_cla (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    idx_d = '0;
`ifdef SUBTRACT_EN
                    // Subtraction is a + ~b + 1, so the external carry-in is ignored.
                    if (sub) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = b;
                        carry_d = cin;
                    end
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q) * SLICE +: SLICE] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench: a 4-slice instance (index 0) and a single-slice instance (index 1) checked against a plain-arithmetic model.
module tb_multiword_adder_seq;

    localparam int W = 128;
`ifdef SUBTRACT_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid_v  [2];
    logic         in_ready_v  [2];
    logic [W-1:0] a_v         [2];
    logic [W-1:0] b_v         [2];
    logic         cin_v       [2];
    logic         sub_v       [2];
    logic         out_valid_v [2];
    logic         out_ready_v [2];
    logic [W-1:0] sum_v       [2];
    logic         cout_v      [2];
    logic         busy_v      [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multiword_adder_seq #(.WIDTH(W), .SLICE(32)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[0]),
        .in_ready  (in_ready_v[0]),
        .a         (a_v[0]),
        .b         (b_v[0]),
        .cin       (cin_v[0]),
`ifdef SUBTRACT_EN
        .sub       (sub_v[0]),
`endif
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready_v[0]),
        .sum       (sum_v[0]),
        .cout      (cout_v[0]),
        .busy      (busy_v[0])
    );

    multiword_adder_seq #(.WIDTH(W), .SLICE(W)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[1]),
        .in_ready  (in_ready_v[1]),
        .a         (a_v[1]),
        .b         (b_v[1]),
        .cin       (cin_v[1]),
`ifdef SUBTRACT_EN
        .sub       (sub_v[1]),
`endif
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready_v[1]),
        .sum       (sum_v[1]),
        .cout      (cout_v[1]),
        .busy      (busy_v[1])
    );

    // Reference: {cout, sum} from whole-number arithmetic; subtraction carry means "no borrow".
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W-1:0] diff;
        if (sub) begin
            diff = a - b;
            return {(a >= b), diff};
        end
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int nslice(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Issues one op, scrambles inputs after acceptance, waits (bounded) for out_valid.
    task automatic run_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input bit hs,
                          output logic [W-1:0] s, output logic co, output int lat);
        int guard = 0;
        in_valid_v[d] = 1'b1; a_v[d] = a; b_v[d] = b; cin_v[d] = cin; sub_v[d] = sub;
        while (!in_ready_v[d] && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0; a_v[d] = rand_word(); b_v[d] = rand_word();
        cin_v[d] = ~cin; sub_v[d] = HAS_SUB ? ~sub : 1'b0;
        lat = 0;
        while (!out_valid_v[d] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        s  = sum_v[d];
        co = cout_v[d];
        if (hs) begin
            out_ready_v[d] = 1'b1;
            @(posedge clk); #1;
            out_ready_v[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b0; out_ready_v[d] = 1'b0;
            a_v[d] = '0; b_v[d] = '0; cin_v[d] = 1'b0; sub_v[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            total++; if (in_ready_v[d] !== 1'b1) begin bad++; $display("FAIL reset_in_ready d=%0d: got %b want 1", d, in_ready_v[d]); end
            total++; if (out_valid_v[d] !== 1'b0) begin bad++; $display("FAIL reset_out_valid d=%0d: got %b want 0", d, out_valid_v[d]); end
            total++; if (busy_v[d] !== 1'b0) begin bad++; $display("FAIL reset_busy d=%0d: got %b want 0", d, busy_v[d]); end
            total++; if (sum_v[d] !== '0) begin bad++; $display("FAIL reset_sum d=%0d: got %h want 0", d, sum_v[d]); end
            total++; if (cout_v[d] !== 1'b0) begin bad++; $display("FAIL reset_cout d=%0d: got %b want 0", d, cout_v[d]); end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: released");
    endtask

    task automatic test_boundaries();
        logic [W-1:0] s;
        logic         co;
        int           lat;
        logic [W-1:0] ones = '1;
        logic [W-1:0] lo32 = {96'd0, 32'hFFFF_FFFF};
        logic [W-1:0] want2 = {95'd0, 1'b1, 32'd0};
        for (int d = 0; d < 2; d++) begin
            run_op(d, ones, 128'd1, 1'b0, 1'b0, 1'b1, s, co, lat);
            $display("boundary wrap d=%0d: sum=%h cout=%b lat=%0d", d, s, co, lat);
            total++; if (s !== '0) begin bad++; $display("FAIL wrap_sum d=%0d: got %h want 0", d, s); end
            total++; if (co !== 1'b1) begin bad++; $display("FAIL wrap_cout d=%0d: got %b want 1", d, co); end
            total++; if (lat != nslice(d)) begin bad++; $display("FAIL wrap_latency d=%0d: got %0d want %0d", d, lat, nslice(d)); end
            run_op(d, lo32, 128'd1, 1'b0, 1'b0, 1'b1, s, co, lat);
            $display("boundary slice-carry d=%0d: sum=%h cout=%b", d, s, co);
            total++; if (s !== want2) begin bad++; $display("FAIL slice_carry_sum d=%0d: got %h want %h", d, s, want2); end
            total++; if (co !== 1'b0) begin bad++; $display("FAIL slice_carry_cout d=%0d: got %b want 0", d, co); end
        end
    endtask

    task automatic test_random(input int d);
        logic [W-1:0] s, ra, rb;
        logic         co, rc, rs;
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < 15; i++) begin
            ra = (i % 5 == 0) ? '1 : rand_word();
            rb = (i % 7 == 3) ? '1 : rand_word();
            rc = 1'($urandom_range(0, 1));
            rs = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
            exp = model(ra, rb, rc, rs);
            run_op(d, ra, rb, rc, rs, 1'b1, s, co, lat);
            $display("random d=%0d #%0d: sub=%b sum=%h cout=%b lat=%0d", d, i, rs, s, co, lat);
            total++; if (s !== exp[W-1:0]) begin bad++; $display("FAIL random_sum d=%0d #%0d: got %h want %h", d, i, s, exp[W-1:0]); end
            total++; if (co !== exp[W]) begin bad++; $display("FAIL random_cout d=%0d #%0d: got %b want %b", d, i, co, exp[W]); end
            total++; if (lat != nslice(d)) begin bad++; $display("FAIL random_latency d=%0d #%0d: got %0d want %0d", d, i, lat, nslice(d)); end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] s, ra, rb;
        logic         co;
        logic [W:0]   exp;
        int           lat;
        ra = rand_word(); rb = rand_word();
        exp = model(ra, rb, 1'b1, 1'b0);
        run_op(0, ra, rb, 1'b1, 1'b0, 1'b0, s, co, lat);
        in_valid_v[0] = 1'b1; a_v[0] = rand_word(); b_v[0] = rand_word();
        for (int i = 0; i < 10; i++) begin
            total++; if (out_valid_v[0] !== 1'b1) begin bad++; $display("FAIL stall_out_valid #%0d: got %b want 1", i, out_valid_v[0]); end
            total++; if (sum_v[0] !== exp[W-1:0]) begin bad++; $display("FAIL stall_sum #%0d: got %h want %h", i, sum_v[0], exp[W-1:0]); end
            total++; if (cout_v[0] !== exp[W]) begin bad++; $display("FAIL stall_cout #%0d: got %b want %b", i, cout_v[0], exp[W]); end
            total++; if (in_ready_v[0] !== 1'b0) begin bad++; $display("FAIL stall_in_ready #%0d: got %b want 0", i, in_ready_v[0]); end
            total++; if (busy_v[0] !== 1'b1) begin bad++; $display("FAIL stall_busy #%0d: got %b want 1", i, busy_v[0]); end
            @(posedge clk); #1;
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        $display("stall: released sum=%h", sum_v[0]);
        total++; if (in_ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin bad++; $display("FAIL stall_release: got ready=%b busy=%b want 1/0", in_ready_v[0], busy_v[0]); end
    endtask

    task automatic test_subtract();
`ifdef SUBTRACT_EN
        logic [W-1:0] s;
        logic         co;
        int           lat;
        logic [W-1:0] want_neg = {{124{1'b1}}, 4'hE};
        for (int d = 0; d < 2; d++) begin
            run_op(d, 128'd5, 128'd7, 1'b1, 1'b1, 1'b1, s, co, lat);
            $display("subtract d=%0d 5-7: sum=%h cout=%b", d, s, co);
            total++; if (s !== want_neg) begin bad++; $display("FAIL sub_neg_sum d=%0d: got %h want %h", d, s, want_neg); end
            total++; if (co !== 1'b0) begin bad++; $display("FAIL sub_neg_cout d=%0d: got %b want 0", d, co); end
            run_op(d, 128'd7, 128'd5, 1'b0, 1'b1, 1'b1, s, co, lat);
            $display("subtract d=%0d 7-5: sum=%h cout=%b", d, s, co);
            total++; if (s !== 128'd2) begin bad++; $display("FAIL sub_pos_sum d=%0d: got %h want 2", d, s); end
            total++; if (co !== 1'b1) begin bad++; $display("FAIL sub_pos_cout d=%0d: got %b want 1", d, co); end
        end
`endif
    endtask

    task automatic test_back_to_back(input int d);
        logic [W-1:0] oa [2];
        logic [W-1:0] ob [2];
        logic         oc [2];
        logic         os [2];
        logic [W-1:0] rs [2];
        logic         rc [2];
        logic [W:0]   exp;
        int acc_cyc [2];
        int dv_cyc  [2];
        int acc = 0, nres = 0, cycle = 0;
        logic pre_rdy, pre_vld;
        for (int k = 0; k < 2; k++) begin
            oa[k] = rand_word(); ob[k] = rand_word();
            oc[k] = 1'($urandom_range(0, 1));
            os[k] = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
            acc_cyc[k] = 0; dv_cyc[k] = 0; rs[k] = '0; rc[k] = 1'b0;
        end
        out_ready_v[d] = 1'b1;
        in_valid_v[d] = 1'b1; a_v[d] = oa[0]; b_v[d] = ob[0]; cin_v[d] = oc[0]; sub_v[d] = os[0];
        while (nres < 2 && cycle < 100) begin
            pre_rdy = in_ready_v[d];
            pre_vld = in_valid_v[d];
            @(posedge clk); #1; cycle++;
            if (pre_rdy && pre_vld && acc < 2) begin
                acc_cyc[acc] = cycle;
                acc++;
                if (acc == 1) begin
                    a_v[d] = oa[1]; b_v[d] = ob[1]; cin_v[d] = oc[1]; sub_v[d] = os[1];
                end else begin
                    in_valid_v[d] = 1'b0;
                end
            end
            if (out_valid_v[d]) begin
                rs[nres] = sum_v[d]; rc[nres] = cout_v[d]; dv_cyc[nres] = cycle;
                nres++;
            end
        end
        @(posedge clk); #1;
        out_ready_v[d] = 1'b0; in_valid_v[d] = 1'b0;
        $display("back_to_back d=%0d: results=%0d acc=%0d,%0d done=%0d,%0d", d, nres, acc_cyc[0], acc_cyc[1], dv_cyc[0], dv_cyc[1]);
        total++; if (nres != 2) begin bad++; $display("FAIL b2b_count d=%0d: got %0d want 2", d, nres); end
        for (int k = 0; k < 2; k++) begin
            exp = model(oa[k], ob[k], oc[k], os[k]);
            total++; if (rs[k] !== exp[W-1:0]) begin bad++; $display("FAIL b2b_sum%0d d=%0d: got %h want %h", k, d, rs[k], exp[W-1:0]); end
            total++; if (rc[k] !== exp[W]) begin bad++; $display("FAIL b2b_cout%0d d=%0d: got %b want %b", k, d, rc[k], exp[W]); end
            total++; if (dv_cyc[k] - acc_cyc[k] != nslice(d)) begin bad++; $display("FAIL b2b_latency%0d d=%0d: got %0d want %0d", k, d, dv_cyc[k] - acc_cyc[k], nslice(d)); end
        end
        total++; if (acc_cyc[1] != dv_cyc[0] + 2) begin bad++; $display("FAIL b2b_issue d=%0d: got accept at %0d want %0d", d, acc_cyc[1], dv_cyc[0] + 2); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s;
        logic         co;
        int           lat;
        in_valid_v[0] = 1'b1; a_v[0] = '1; b_v[0] = rand_word(); cin_v[0] = 1'b1; sub_v[0] = 1'b0;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (busy_v[0] !== 1'b1) begin bad++; $display("FAIL midreset_busy_before: got %b want 1", busy_v[0]); end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid_v[0] !== 1'b0) begin bad++; $display("FAIL midreset_out_valid #%0d: got %b want 0", i, out_valid_v[0]); end
            @(posedge clk); #1;
        end
        total++; if (sum_v[0] !== '0) begin bad++; $display("FAIL midreset_sum: got %h want 0", sum_v[0]); end
        total++; if (in_ready_v[0] !== 1'b1) begin bad++; $display("FAIL midreset_in_ready: got %b want 1", in_ready_v[0]); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || sum_v[0] !== '0) begin
            bad++; $display("FAIL midreset_after: got valid=%b ready=%b sum=%h want 0/1/0", out_valid_v[0], in_ready_v[0], sum_v[0]);
        end
        run_op(0, 128'd3, 128'd4, 1'b0, 1'b0, 1'b1, s, co, lat);
        $display("midreset: next op 3+4 sum=%h cout=%b", s, co);
        total++; if (s !== 128'd7) begin bad++; $display("FAIL midreset_next_sum: got %h want 7", s); end
        total++; if (co !== 1'b0) begin bad++; $display("FAIL midreset_next_cout: got %b want 0", co); end
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_random(0);
        test_random(1);
        test_stall();
        test_subtract();
        test_back_to_back(0);
        test_back_to_back(1);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
